viterbi_obs_streamer: RTL

VITERBI_OBS_STREAMER -- requirements
Module: viterbi_obs_streamer

---
 rtl/viterbi_obs_streamer.sv | 119 +++++++++++
 1 files changed

// File: rtl/viterbi_obs_streamer.sv
// Buffers one frame of host observation symbols, then replays it to a Viterbi decoder.
// Optional range checking of accepted symbols is compiled in with VITERBI_OBS_RANGE_CHECK_EN.
module viterbi_obs_streamer #(
  parameter int K  = 3,
  parameter int N  = 5,
  parameter int KW = $clog2(K),
  parameter int LW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] s_obs,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  output logic          start,
  output logic [LW-1:0] length,
  output logic [KW-1:0] obs_in,
  output logic          obs_valid,
  input  logic          dec_done,
  output logic          busy,
  output logic          err
);

  // state  | meaning
  // IDLE   | collecting symbols from the host into the buffer
  // START  | one-cycle frame-start pulse to the decoder
  // STREAM | replaying buffer[0..length-1], one symbol per cycle
  // WAIT   | frame handed over; waiting for the decoder to finish
  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT} state_t;

  localparam int AW = (N > 1) ? $clog2(N) : 1;

  state_t        state, state_next;
  logic [KW-1:0] sym_mem [N];
  logic [LW-1:0] cnt, rd, cnt_inc;
  logic          hs, close, reject, last_rd;

  assign cnt_inc = cnt + LW'(1);
  assign hs      = s_valid & s_ready;
  assign close   = hs & (s_last | (cnt_inc == LW'(N)));
  assign last_rd = (rd == length - LW'(1));

`ifdef VITERBI_OBS_RANGE_CHECK_EN
  logic bad, sym_bad, err_q;

  assign sym_bad = hs & (32'(s_obs) >= K);
  // The offending symbol may be the closing one, so it counts alongside the sticky flag.
  assign reject  = close & (bad | sym_bad);
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
      if (close)
        bad <= 1'b0;
      else if (sym_bad)
        bad <= 1'b1;
    end
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (close) state_next = reject ? IDLE : START;
      START:   state_next = STREAM;
      STREAM:  if (last_rd) state_next = WAIT;
      WAIT:    if (dec_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign s_ready   = (state == IDLE) && (cnt < LW'(N));
  assign start     = (state == START);
  assign obs_valid = (state == STREAM);
  assign busy      = (state != IDLE);
  assign obs_in    = obs_valid ? sym_mem[rd[AW-1:0]] : '0;

  // Buffer contents survive reset; a discarded frame is simply overwritten.
  always_ff @(posedge clk) begin
    if (hs)
      sym_mem[cnt[AW-1:0]] <= s_obs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rd     <= '0;
      length <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (hs)
            cnt <= reject ? '0 : cnt_inc;
          if (close && !reject)
            length <= cnt_inc;
        end
        START:  rd <= '0;
        STREAM: rd <= rd + LW'(1);
        WAIT: begin
          if (dec_done) begin
            cnt <= '0;
            rd  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
